// File: rtl/aer_tx_scheduler.sv
// aer_tx_scheduler: latches per-pixel events and sends them one at a time over a 4-phase AER bus,
// choosing rows and then columns round-robin.
module aer_tx_scheduler #(
    parameter int ROWS = 2,
    parameter int COLS = 4,
    parameter int CNT_W = 8,
    localparam int N = ROWS * COLS,
    localparam int ROW_W = ROWS > 1 ? $clog2(ROWS) : 1,
    localparam int COL_W = COLS > 1 ? $clog2(COLS) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     ev_in,
    input  logic [N-1:0]     ev_pol,
    input  logic             tx_en,
    input  logic             aer_ack,
    output logic             aer_req,
    output logic [ROW_W-1:0] aer_row,
    output logic [COL_W-1:0] aer_col,
    output logic             aer_on,
    output logic             busy,
    output logic [CNT_W-1:0] ovf_cnt
);
    typedef enum logic [2:0] {IDLE, ROW, COL, REQ, RELEASE} state_t;
    state_t state;
    logic [N-1:0] pend, pol, clr, take;
    logic [ROWS-1:0] row_any;
    logic [COLS-1:0] cur, cur_pol;
    logic [ROW_W-1:0] row_ptr, grow, row_nx;
    logic [COL_W-1:0] col_ptr, gcol, col_nx;
    logic drop;

    assign cur = COLS'(pend >> (aer_row * COLS));
    assign cur_pol = COLS'(pol >> (aer_row * COLS));
    assign clr = {N{state == REQ && aer_ack}} & (N'(1) << (aer_row * COLS + aer_col));
    // a new event on the clearing edge re-arms the latch instead of counting as a drop
    assign take = ev_in & ~(pend & ~clr);
    assign drop = |(ev_in & pend & ~clr);
    assign row_nx = (aer_row == ROW_W'(ROWS - 1)) ? '0 : aer_row + 1'b1;
    assign col_nx = (gcol == COL_W'(COLS - 1)) ? '0 : gcol + 1'b1;

    always_comb begin
        for (int r = 0; r < ROWS; r++) row_any[r] = |pend[r*COLS +: COLS];
    end

    // second pass overrides with the first hit at or above the pointer, giving wrap-around priority
    always_comb begin
        grow = row_ptr;
        for (int r = ROWS - 1; r >= 0; r--) if (row_any[r]) grow = ROW_W'(r);
        for (int r = ROWS - 1; r >= 0; r--) if (row_any[r] && ROW_W'(r) >= row_ptr) grow = ROW_W'(r);
    end

    always_comb begin
        gcol = col_ptr;
        for (int c = COLS - 1; c >= 0; c--) if (cur[c]) gcol = COL_W'(c);
        for (int c = COLS - 1; c >= 0; c--) if (cur[c] && COL_W'(c) >= col_ptr) gcol = COL_W'(c);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            pend    <= '0;
            pol     <= '0;
            row_ptr <= '0;
            col_ptr <= '0;
            aer_req <= 1'b0;
            aer_row <= '0;
            aer_col <= '0;
            aer_on  <= 1'b0;
            busy    <= 1'b0;
            ovf_cnt <= '0;
        end else begin
            pend <= (pend & ~clr) | ev_in;
            pol  <= (pol & ~take) | (ev_pol & take);
            if (drop && ovf_cnt != '1) ovf_cnt <= ovf_cnt + 1'b1;
            case (state)
                IDLE: if (tx_en && |pend && !aer_ack) begin
                    state <= ROW;
                    busy  <= 1'b1;
                end
                ROW: begin
                    aer_row <= grow;
                    state   <= COL;
                end
                COL: begin
                    aer_col <= gcol;
                    aer_on  <= cur_pol[gcol];
                    col_ptr <= col_nx;
                    aer_req <= 1'b1;
                    state   <= REQ;
                end
                REQ: if (aer_ack) begin
                    aer_req <= 1'b0;
                    state   <= RELEASE;
                end
                RELEASE: if (!aer_ack) begin
                    if (!tx_en) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (|cur) begin
                        state <= COL;
                    end else begin
                        row_ptr <= row_nx;
                        state   <= |pend ? ROW : IDLE;
                        busy    <= |pend;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
